// File: rtl/spi_arbiter.sv
// Round-robin arbiter granting NREQ requesters exclusive use of one SPI byte engine.
// Each grant runs 1..4 bytes under a single cs-low window, with a per-byte timeout.
module spi_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   len,
  input  logic [8*NREQ-1:0]   tx_data,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     byte_ack,
  output logic [7:0]          rx_data,
  output logic [NREQ-1:0]     rx_valid,
  output logic [NREQ-1:0]     txn_done,
  output logic [NREQ-1:0]     err,
  output logic                cs,
  output logic                spi_start,
  output logic [7:0]          spi_tx,
  input  logic                spi_done,
  input  logic [7:0]          spi_rx
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   pick_next;
  logic [1:0]      cnt;
  logic [TW-1:0]   timer;
  logic [7:0]      cur_tx;

  // NOTE: combinational logic uses blocking '=' with a default assigned first,
  // so every path drives every signal and no latch is inferred.
  always_comb begin
    int idx;
    pick = ptr;
    // Scanning from the farthest offset down lets the requester closest to ptr win.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) pick = PW'(idx);
    end
    pick_next = (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);
    cur_tx    = tx_data[8*int'(winner) +: 8];
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      cnt       <= '0;
      timer     <= '0;
      cs        <= 1'b1;
      gnt       <= '0;
      spi_start <= 1'b0;
      spi_tx    <= '0;
      byte_ack  <= '0;
      rx_data   <= '0;
      rx_valid  <= '0;
      txn_done  <= '0;
      err       <= '0;
    end else begin
      spi_start <= 1'b0;
      byte_ack  <= '0;
      rx_valid  <= '0;
      txn_done  <= '0;
      err       <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            winner <= pick;
            ptr    <= pick_next;
            gnt    <= NREQ'(1) << pick;
            cnt    <= len[2*int'(pick) +: 2];
            cs     <= 1'b0;
            state  <= SETUP;
          end else begin
            cs  <= 1'b1;
            gnt <= '0;
          end
        end
        SETUP: begin
          spi_start <= 1'b1;
          spi_tx    <= cur_tx;
          byte_ack  <= gnt;
          state     <= START;
        end
        START: begin
          // The launch cycle counts, so err lands exactly TIMEOUT cycles after spi_start.
          timer <= TW'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (spi_done) begin
            rx_data  <= spi_rx;
            rx_valid <= gnt;
            if (cnt == 2'd0) begin
              txn_done <= gnt;
              gnt      <= '0;
              cs       <= 1'b1;
              state    <= HOLD;
            end else begin
              cnt       <= cnt - 2'd1;
              spi_start <= 1'b1;
              spi_tx    <= cur_tx;
              byte_ack  <= gnt;
              state     <= START;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err   <= gnt;
            gnt   <= '0;
            cs    <= 1'b1;
            state <= HOLD;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        HOLD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing one spi_master byte engine (2..8).
REQ-002 Parameter TIMEOUT, default 1023: maximum cycles WAIT may last before abort.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester transaction request, level.
REQ-006 len  input  2*NREQ  per-requester byte count minus 1 (0..3 = 1..4 bytes); slice i = len[2i+1:2i].
REQ-007 tx_data  input  8*NREQ  per-requester next TX byte; slice i = tx_data[8i+7:8i].
REQ-008 gnt  output  NREQ  one-hot grant, held for the whole transaction.
REQ-009 byte_ack  output  NREQ  one-cycle pulse to the granted requester when its tx_data slice has been consumed.
REQ-010 rx_data  output  8  last received byte.
REQ-011 rx_valid  output  NREQ  one-cycle pulse to the granted requester, coincident with new rx_data.
REQ-012 txn_done  output  NREQ  one-cycle pulse, successful transaction end.
REQ-013 err  output  NREQ  one-cycle pulse, transaction aborted on timeout.
REQ-014 cs  output  1  SPI chip select, active-low, held low across all bytes of a transaction.
REQ-015 spi_start  output  1  one-cycle pulse launching one byte on the byte engine.
REQ-016 spi_tx  output  8  byte to transmit, valid while spi_start=1.
REQ-017 spi_done  input  1  byte-engine completion pulse.
REQ-018 spi_rx  input  8  received byte, valid while spi_done=1.

Function
REQ-019 States SHALL be IDLE, SETUP, START, WAIT, HOLD.
REQ-020 IDLE: if any req bit is 1, winner = first set bit scanning upward from ptr, wrapping; next cycle gnt=onehot(winner), cnt=len slice, cs=0, state SETUP.
REQ-021 IDLE with req=0: remain IDLE, cs=1, gnt=0.
REQ-022 Round-robin pointer ptr SHALL become (winner+1) mod NREQ at grant; ptr resets to 0.
REQ-023 SETUP lasts exactly 1 cycle (cs setup), then START.
REQ-024 START: spi_start=1 for 1 cycle, spi_tx = granted tx_data slice, byte_ack pulse to winner in the same cycle; next state WAIT, timer cleared.
REQ-025 WAIT: on spi_done capture spi_rx into rx_data, rx_valid pulse next cycle; if cnt=0 go HOLD with txn_done pulse, else cnt-1 and go START.
REQ-026 Minimum spacing between spi_start pulses SHALL be 2 cycles (START, WAIT, START).
REQ-027 WAIT timer increments each cycle; at TIMEOUT without spi_done: err pulse to winner, go HOLD, no rx_valid, no txn_done.
REQ-028 HOLD lasts exactly 1 cycle: cs=1, gnt=0; then IDLE. Guarantees >=1 cycle cs-high gap between transactions.
REQ-029 req deassertion after grant SHALL be ignored; the transaction runs to completion or timeout.
REQ-030 len and req changes after grant SHALL not affect cnt or winner.
REQ-031 spi_done outside WAIT SHALL be ignored.
REQ-032 spi_done in the same cycle the timer reaches TIMEOUT SHALL count as success (done wins).
REQ-033 gnt, byte_ack, rx_valid, txn_done, err SHALL each be zero or one-hot, and only to the winner.

Reset
REQ-034 On rst=1 at a clock edge: state IDLE, cs=1, gnt=0, spi_start=0, spi_tx=0, byte_ack=0, rx_data=0, rx_valid=0, txn_done=0, err=0, ptr=0, cnt=0, timer=0.
REQ-035 Reset mid-transaction SHALL abort immediately with no txn_done or err pulse; the byte engine is reset by the same rst.
REQ-036 First grant after reset SHALL go to the lowest-index requesting port.

Verification
REQ-037 Single: req=001, len0=2, tx bytes A5,3C,F0, engine done after 8 cycles -> three spi_start pulses with spi_tx A5,3C,F0, cs low throughout, txn_done[0] once, then cs=1 for >=1 cycle.
REQ-038 Fairness: req=111 held constantly, len=0 -> grant order 0,1,2,0,1,2; each gnt one-hot; cs-high gap between each.
REQ-039 Timeout: TIMEOUT=15, engine never asserts spi_done -> err[winner] 15 cycles after spi_start, no rx_valid, cs returns to 1, next request served normally.
REQ-040 Request drop: req[1] deasserted in WAIT of byte 1 of 3 -> all 3 bytes still issued, txn_done[1] asserted.
REQ-041 Reset mid-op: rst=1 during WAIT of byte 2 -> next edge cs=1, gnt=0, no txn_done/err; next grant with req=110 goes to port 1.
REQ-042 Spurious done: spi_done pulsed in IDLE and SETUP -> no rx_valid, state unchanged.
